// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its request queue.
package dmem_pkg;

  localparam int unsigned TAG_W  = 7;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned CMD_W  = 5;
  localparam int unsigned MASK_W = DATA_W / 8;

  localparam logic [CMD_W-1:0] CMD_LOAD  = 5'd0;
  localparam logic [CMD_W-1:0] CMD_STORE = 5'd1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } dmem_req_t;

  function automatic logic cmd_is_legal(input logic [CMD_W-1:0] cmd);
    return (cmd == CMD_LOAD) || (cmd == CMD_STORE);
  endfunction

endpackage

// File: rtl/dmem_req_queue.sv
// Synchronous request FIFO with occupancy count; pushes while full and pops while empty are ignored.
module dmem_req_queue
  import dmem_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  dmem_req_t                    data_i,
  input  logic                         pop_i,
  output dmem_req_t                    data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  dmem_req_t         mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              push, pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency 64-bit data-memory model: queued requests, byte-masked stores,
// loads answered through a non-stalling LATENCY-deep response pipeline.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned QDEPTH    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dmem_req_valid,
  output logic              dmem_req_ready,
  input  logic [ADDR_W-1:0] dmem_req_addr,
  input  logic [TAG_W-1:0]  dmem_req_tag,
  input  logic [CMD_W-1:0]  dmem_req_cmd,
  input  logic [2:0]        dmem_req_size,
  input  logic [DATA_W-1:0] dmem_req_wdata,
  input  logic [MASK_W-1:0] dmem_req_wmask,
  input  logic              stall,
  output logic              dmem_resp_valid,
  output logic [TAG_W-1:0]  dmem_resp_tag,
  output logic [DATA_W-1:0] dmem_resp_rdata,
  output logic              busy,
  output logic              err
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);
  localparam int unsigned CntW = $clog2(QDEPTH + 1);

  dmem_req_t         req_in, head;
  logic              q_full, q_empty;
  logic [CntW-1:0]   q_count;
  logic              accept, issue, is_load, is_store;
  logic [IdxW-1:0]   idx;

  assign req_in = '{addr: dmem_req_addr, tag: dmem_req_tag, cmd: dmem_req_cmd,
                    wdata: dmem_req_wdata, wmask: dmem_req_wmask};

  assign dmem_req_ready = ~q_full;
  assign accept         = dmem_req_valid & dmem_req_ready;
  assign issue          = ~q_empty & ~stall;
  assign is_load        = (head.cmd == CMD_LOAD);
  assign is_store       = (head.cmd == CMD_STORE);
  assign idx            = head.addr[3 +: IdxW];

  dmem_req_queue #(
    .Depth(QDEPTH)
  ) u_req_queue (
    .clk_i  (clock),
    .rst_ni (reset),
    .push_i (accept),
    .data_i (req_in),
    .pop_i  (issue),
    .data_o (head),
    .full_o (q_full),
    .empty_o(q_empty),
    .count_o(q_count)
  );

  // Size is ignored and only the word-index bits of the address matter.
  logic unused_bits;
  assign unused_bits = ^{dmem_req_size, head.addr[ADDR_W-1:3+IdxW], head.addr[2:0]};

  // Backing store is deliberately left out of reset so contents survive it.
  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  always_ff @(posedge clock) begin
    if (issue && is_store) begin
      for (int i = 0; i < int'(MASK_W); i++) begin
        if (head.wmask[i]) mem_q[idx][8*i +: 8] <= head.wdata[8*i +: 8];
      end
    end
  end

  logic              s0_valid;
  logic [TAG_W-1:0]  s0_tag;
  logic [DATA_W-1:0] s0_data;

  assign s0_valid = issue & is_load;
  assign s0_tag   = s0_valid ? head.tag : '0;
  assign s0_data  = s0_valid ? mem_q[idx] : '0;

  logic              pipe_valid_q [LATENCY];
  logic [TAG_W-1:0]  pipe_tag_q   [LATENCY];
  logic [DATA_W-1:0] pipe_data_q  [LATENCY];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_tag_q[i]   <= '0;
        pipe_data_q[i]  <= '0;
      end
    end else begin
      pipe_valid_q[0] <= s0_valid;
      pipe_tag_q[0]   <= s0_tag;
      pipe_data_q[0]  <= s0_data;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_tag_q[i]   <= pipe_tag_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
      end
    end
  end

  logic pipe_busy;
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < int'(LATENCY); i++) pipe_busy = pipe_busy | pipe_valid_q[i];
  end

  assign dmem_resp_valid = pipe_valid_q[LATENCY-1];
  assign dmem_resp_tag   = dmem_resp_valid ? pipe_tag_q[LATENCY-1]  : '0;
  assign dmem_resp_rdata = dmem_resp_valid ? pipe_data_q[LATENCY-1] : '0;
  assign busy            = (q_count != '0) | pipe_busy;

  logic err_q, err_d;
  assign err_d = err_q | (accept & ~cmd_is_legal(dmem_req_cmd));
  assign err   = err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 256, SHALL set the number of 64-bit backing words (power of two).
REQ-002 Parameter LATENCY, default 2, SHALL set the cycles from issue to response (range 1..8).
REQ-003 Parameter QDEPTH, default 4, SHALL set the request queue depth (power of two, at least 2).
REQ-004 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 dmem_req_valid  input  1  SHALL indicate a request is presented.
REQ-007 dmem_req_ready  output  1  SHALL indicate a request can be accepted this cycle.
REQ-008 dmem_req_addr  input  64  SHALL be the byte address.
REQ-009 dmem_req_tag  input  7  SHALL be the request tag.
REQ-010 dmem_req_cmd  input  5  SHALL be the command: 0 load, 1 store.
REQ-011 dmem_req_size  input  3  SHALL be accepted and ignored; every access is 64-bit.
REQ-012 dmem_req_wdata  input  64  SHALL be the store data.
REQ-013 dmem_req_wmask  input  8  SHALL be the store byte-enable mask.
REQ-014 stall  input  1  SHALL hold queue issue while high; used for backpressure testing.
REQ-015 dmem_resp_valid  output  1  SHALL mark a valid load response (single-cycle pulse; no ready).
REQ-016 dmem_resp_tag  output  7  SHALL return the tag of the load being answered.
REQ-017 dmem_resp_rdata  output  64  SHALL return the load data.
REQ-018 busy  output  1  SHALL be high while the queue or the response pipeline holds any entry.
REQ-019 err  output  1  SHALL be a sticky flag, set when a command other than 0 or 1 is accepted.

Function
REQ-020 A request SHALL be accepted in any cycle where dmem_req_valid and dmem_req_ready are both high, and written into the request queue.
REQ-021 dmem_req_ready SHALL be high exactly when the queue occupancy is below QDEPTH; it SHALL NOT depend on stall or dmem_req_valid.
REQ-022 When the queue is non-empty and stall is low, the head entry SHALL issue (pop) in that cycle, at a rate of one entry per cycle.
REQ-023 Push and pop in the same cycle SHALL leave occupancy unchanged; push when full SHALL be impossible.
REQ-024 Word index SHALL be addr[3 +: log2(MEM_WORDS)]; addr[2:0] and the upper bits SHALL be ignored, so addresses wrap modulo the memory size.
REQ-025 An issued store SHALL update each byte i of the indexed word where wmask[i]=1, in the issue cycle, and SHALL produce no response.
REQ-026 An issued load SHALL read the indexed word in its issue cycle, reflecting all stores issued earlier.
REQ-027 An issued load SHALL drive dmem_resp_valid=1 with its tag and data exactly LATENCY cycles after its issue cycle.
REQ-028 With an empty queue and stall low, a load accepted in cycle N SHALL respond in cycle N+1+LATENCY.
REQ-029 Responses SHALL return in acceptance order; the response pipeline SHALL never stall.
REQ-030 An issued command other than 0 or 1 SHALL be a no-op with no response, and SHALL set err.
REQ-031 When dmem_resp_valid is 0, dmem_resp_tag and dmem_resp_rdata SHALL be 0.

Reset
REQ-032 While reset is low: queue empty, pipeline cleared, dmem_resp_valid=0, dmem_resp_tag=0, dmem_resp_rdata=0, busy=0, err=0, dmem_req_ready=1.
REQ-033 Reset assertion mid-operation SHALL discard every queued and in-flight request; no response SHALL appear after reset is released.
REQ-034 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-035 A shared package dmem_pkg SHALL hold the command codes (CMD_LOAD=0, CMD_STORE=1), the tag width 7, and the data width 64.
REQ-036 The request queue SHALL be a sub-module, dmem_req_queue: a synchronous FIFO with occupancy count, full/empty flags, and the same asynchronous active-low reset.
REQ-037 The response path SHALL be a LATENCY-deep shift pipeline of {valid, tag, data} inside dmem_responder.

Verification
REQ-038 Store addr 0x10, wdata 0x1122334455667788, wmask 0xFF; then load addr 0x10, tag 5 -> one response with tag 5 and rdata 0x1122334455667788, 3 cycles after load acceptance.
REQ-039 Store wdata all-ones, wmask 0x0F, over an old value of 0 -> a later load returns 0x00000000FFFFFFFF.
REQ-040 Hold stall high and push 4 loads -> dmem_req_ready falls after the 4th acceptance; release stall -> 4 responses on consecutive cycles, tags in order.
REQ-041 Load addr 0x800 with MEM_WORDS=256 -> returns the same data as addr 0x0.
REQ-042 Accept 2 loads, then pull reset low for 1 cycle -> no responses afterwards; ready=1; busy=0.
REQ-043 Accept cmd 7 -> no response is produced, and err stays 1 until reset.
